// File: rtl/instruction_fetcher.sv
// instruction_fetcher: fetch stage with valid/ready program-memory reads and a one-entry last-fetch buffer
module instruction_fetcher #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int HOLD_BUFFER = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic                             buf_hit
);
  typedef enum logic [2:0] {IDLE = 3'b000, FETCHING = 3'b001, FETCHED = 3'b010} state_t;
  localparam logic [2:0] CORE_FETCH = 3'b001, CORE_DECODE = 3'b010;
  localparam logic HB = HOLD_BUFFER != 0;
  state_t state;
  logic buf_valid;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] buf_addr;
  logic [PROGRAM_MEM_DATA_BITS-1:0] buf_data;
  logic hit;
  assign hit = HB && buf_valid && buf_addr == current_pc && !flush;
  assign fetcher_state = state;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      mem_read_valid <= 1'b0;
      mem_read_address <= '0;
      instruction <= '0;
      buf_hit <= 1'b0;
      buf_valid <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
    end else begin
      buf_hit <= 1'b0;
      if (flush) buf_valid <= 1'b0;
      case (state)
        IDLE: if (core_state == CORE_FETCH) begin
          if (hit) begin
            instruction <= buf_data;
            buf_hit <= 1'b1;
            state <= FETCHED;
          end else begin
            mem_read_valid <= 1'b1;
            mem_read_address <= current_pc;
            state <= FETCHING;
          end
        end
        FETCHING: if (mem_read_ready) begin
          mem_read_valid <= 1'b0;
          instruction <= mem_read_data;
          buf_addr <= mem_read_address;
          buf_data <= mem_read_data;
          buf_valid <= HB && !flush;
          state <= FETCHED;
        end
        FETCHED: if (core_state == CORE_DECODE) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_fetcher.sv
// tb_instruction_fetcher: directed self-checking bench for instruction_fetcher
module tb_instruction_fetcher;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [2:0] core_state = 3'd0;
  logic [7:0] current_pc = 8'd0;
  logic flush = 1'b0;
  logic mem_read_valid;
  logic [7:0] mem_read_address;
  logic mem_read_ready = 1'b0;
  logic [15:0] mem_read_data = 16'd0;
  logic [2:0] fetcher_state;
  logic [15:0] instruction;
  logic buf_hit;
  logic [2:0] core_state_z = 3'd0;
  logic [7:0] current_pc_z = 8'd0;
  logic mem_read_valid_z;
  logic [7:0] mem_read_address_z;
  logic mem_read_ready_z = 1'b0;
  logic [15:0] mem_read_data_z = 16'd0;
  logic [2:0] fetcher_state_z;
  logic [15:0] instruction_z;
  logic buf_hit_z;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_fetcher #(.PROGRAM_MEM_ADDR_BITS(8), .PROGRAM_MEM_DATA_BITS(16), .HOLD_BUFFER(1)) dut (
    .clk(clk), .reset(reset), .core_state(core_state), .current_pc(current_pc), .flush(flush),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .fetcher_state(fetcher_state), .instruction(instruction), .buf_hit(buf_hit));

  instruction_fetcher #(.PROGRAM_MEM_ADDR_BITS(8), .PROGRAM_MEM_DATA_BITS(16), .HOLD_BUFFER(0)) dut_z (
    .clk(clk), .reset(reset), .core_state(core_state_z), .current_pc(current_pc_z), .flush(1'b0),
    .mem_read_valid(mem_read_valid_z), .mem_read_address(mem_read_address_z),
    .mem_read_ready(mem_read_ready_z), .mem_read_data(mem_read_data_z),
    .fetcher_state(fetcher_state_z), .instruction(instruction_z), .buf_hit(buf_hit_z));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_miss(input logic [7:0] pc, input logic [15:0] d, input int dly, input logic fl_fill, input logic fl_req);
    core_state = 3'b001;
    current_pc = pc;
    flush = fl_req;
    tick();
    flush = 1'b0;
    core_state = 3'b000;
    check("req_valid", mem_read_valid, 1);
    check("req_addr", mem_read_address, pc);
    check("req_state", fetcher_state, 3'b001);
    check("req_hit", buf_hit, 0);
    for (int i = 0; i < dly; i++) begin
      tick();
      check("hold_valid", mem_read_valid, 1);
      check("hold_addr", mem_read_address, pc);
    end
    mem_read_ready = 1'b1;
    mem_read_data = d;
    flush = fl_fill;
    tick();
    mem_read_ready = 1'b0;
    flush = 1'b0;
    check("fill_state", fetcher_state, 3'b010);
    check("fill_instr", instruction, d);
    check("fill_valid", mem_read_valid, 0);
    core_state = 3'b010;
    tick();
    core_state = 3'b000;
    check("decode_idle", fetcher_state, 3'b000);
  endtask

  task automatic fetch_hit(input logic [7:0] pc, input logic [15:0] d);
    core_state = 3'b001;
    current_pc = pc;
    tick();
    core_state = 3'b010;
    check("hit_state", fetcher_state, 3'b010);
    check("hit_pulse", buf_hit, 1);
    check("hit_novalid", mem_read_valid, 0);
    check("hit_instr", instruction, d);
    tick();
    core_state = 3'b000;
    check("hit_pulse_end", buf_hit, 0);
    check("hit_idle", fetcher_state, 3'b000);
  endtask

  initial begin
    tick();
    tick();
    check("rst_state", fetcher_state, 0);
    check("rst_valid", mem_read_valid, 0);
    check("rst_addr", mem_read_address, 0);
    check("rst_instr", instruction, 0);
    check("rst_hit", buf_hit, 0);
    reset = 1'b1;
    tick();
    fetch_miss(8'h10, 16'h3123, 3, 1'b0, 1'b0);
    mem_read_ready = 1'b1;
    mem_read_data = 16'hFFFF;
    tick();
    mem_read_ready = 1'b0;
    check("stray_idle_instr", instruction, 16'h3123);
    check("stray_idle_state", fetcher_state, 0);
    check("stray_idle_valid", mem_read_valid, 0);
    fetch_hit(8'h10, 16'h3123);
    core_state = 3'b001;
    current_pc = 8'h10;
    tick();
    core_state = 3'b000;
    mem_read_ready = 1'b1;
    mem_read_data = 16'hFFFF;
    tick();
    mem_read_ready = 1'b0;
    check("stray_fetched_instr", instruction, 16'h3123);
    check("stray_fetched_state", fetcher_state, 3'b010);
    core_state = 3'b010;
    tick();
    core_state = 3'b000;
    fetch_miss(8'h11, 16'h2222, 1, 1'b0, 1'b0);
    fetch_hit(8'h11, 16'h2222);
    fetch_miss(8'h10, 16'h4444, 0, 1'b0, 1'b0);
    fetch_miss(8'h20, 16'h5555, 2, 1'b1, 1'b0);
    fetch_miss(8'h20, 16'h6666, 0, 1'b0, 1'b0);
    fetch_miss(8'h20, 16'h7777, 1, 1'b0, 1'b1);
    fetch_hit(8'h20, 16'h7777);
    core_state = 3'b001;
    current_pc = 8'h05;
    tick();
    core_state = 3'b000;
    check("pre_rst_valid", mem_read_valid, 1);
    check("pre_rst_addr", mem_read_address, 8'h05);
    #2 reset = 1'b0;
    #1;
    check("arst_valid", mem_read_valid, 0);
    check("arst_state", fetcher_state, 0);
    check("arst_instr", instruction, 0);
    check("arst_hit", buf_hit, 0);
    check("arst_addr", mem_read_address, 0);
    reset = 1'b1;
    mem_read_ready = 1'b1;
    mem_read_data = 16'hFFFF;
    tick();
    mem_read_ready = 1'b0;
    check("post_rst_ready_state", fetcher_state, 0);
    check("post_rst_ready_instr", instruction, 0);
    check("post_rst_ready_valid", mem_read_valid, 0);
    fetch_miss(8'h20, 16'h1234, 0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      core_state_z = 3'b001;
      current_pc_z = 8'h30;
      tick();
      core_state_z = 3'b000;
      check("nb_req_valid", mem_read_valid_z, 1);
      check("nb_req_addr", mem_read_address_z, 8'h30);
      check("nb_hit", buf_hit_z, 0);
      mem_read_ready_z = 1'b1;
      mem_read_data_z = 16'hA000 + 16'(k);
      tick();
      mem_read_ready_z = 1'b0;
      check("nb_instr", instruction_z, 16'hA000 + 16'(k));
      check("nb_hit_after", buf_hit_z, 0);
      core_state_z = 3'b010;
      tick();
      core_state_z = 3'b000;
      check("nb_idle", fetcher_state_z, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
